// File: rtl/apb_regbus_bridge_if.sv
// apb_regbus_bridge_if
//   APB3 completer-side signal bundle shared by the bridge and whatever drives it.
//   Parameters: PADDR_WIDTH (APB address width), DATA_WIDTH (data width).
//   Signals: psel, penable, pwrite, paddr, pwdata (requester -> completer);
//            prdata, pready, pslverr (completer -> requester).
//   Modports: master (the requester), slave (the bridge).
interface apb_regbus_bridge_if #(
  parameter int PADDR_WIDTH = 12,
  parameter int DATA_WIDTH  = 32
);
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [PADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]  pwdata;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regbus_bridge.sv
// apb_regbus_bridge
//   APB3 completer that turns each APB transfer into one strobe-style access on
//   the register bus of a single downstream register-file block. Wait states are
//   inserted with pready; out-of-range addresses (and, optionally, read timeouts)
//   are reported through pslverr.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     apb (slave)       psel, penable, pwrite, paddr, pwdata / prdata, pready, pslverr
//     reg_addr          register-bus address (latched in the setup phase)
//     reg_cs            chip select (WR and RD states)
//     reg_we / reg_re   write / read enables
//     reg_wdata         register-bus write data (latched in the setup phase)
//     reg_rdata         read data from the register file (valid while cs & re)
//     reg_data_valid    read data valid strobe from the register file
//
//   Optional build macro: APB_REGBUS_TIMEOUT_EN
//     When defined, a read that sees no reg_data_valid within TIMEOUT_CYCLES
//     RD cycles completes with pslverr=1 and prdata=0. When undefined, RD waits
//     indefinitely.
//
//   state | meaning
//   IDLE  | waiting for an APB setup phase
//   WR    | single-cycle register-bus write strobe
//   RD    | read strobes held until reg_data_valid (or timeout)
//   RESP  | pready=1, waiting for the APB access phase to complete
module apb_regbus_bridge #(
  parameter int PADDR_WIDTH    = 12,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_regbus_bridge_if.slave    apb,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_cs,
  output logic                  reg_we,
  output logic                  reg_re,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_data_valid
);

  if (ADDR_WIDTH > PADDR_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_regbus_bridge: ADDR_WIDTH must not exceed PADDR_WIDTH and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    addr_oor;

`ifdef APB_REGBUS_TIMEOUT_EN
  // Down-counter loaded on RD entry; reaching zero marks the last allowed RD cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

  // Any address bit above the register-bus window makes the access out of range.
  assign addr_oor = (apb.paddr >> ADDR_WIDTH) != '0;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
`ifdef APB_REGBUS_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // penable without a preceding setup phase falls through untouched.
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr[ADDR_WIDTH-1:0];
          wdata_d = apb.pwdata;
          if (addr_oor) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (apb.pwrite) begin
            state_d = WR;
          end else begin
            state_d = RD;
`ifdef APB_REGBUS_TIMEOUT_EN
            tmo_cnt_d = CNT_LOAD;
`endif
          end
        end
      end
      WR: begin
        if (!apb.psel) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      RD: begin
        if (!apb.psel) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else if (reg_data_valid) begin
          // Captured while the strobes are still up, so reg_rdata is valid here.
          prdata_d = reg_rdata;
          state_d  = RESP;
`ifdef APB_REGBUS_TIMEOUT_EN
        end else if (tmo_cnt_q == '0) begin
          err_d    = 1'b1;
          prdata_d = '0;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
`endif
        end
      end
      RESP: begin
        if (!apb.psel || apb.penable) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
    end
  end

`ifdef APB_REGBUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // All outputs decode registered state only.
  assign apb.pready  = (state_q == RESP);
  assign apb.pslverr = (state_q == RESP) && err_q;
  assign apb.prdata  = prdata_q;
  assign reg_cs      = (state_q == WR) || (state_q == RD);
  assign reg_we      = (state_q == WR);
  assign reg_re      = (state_q == RD);
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// tb_apb_regbus_bridge
//   Directed bench for apb_regbus_bridge. A register-file slave model answers
//   the register bus; a transaction-level model derives the expected output
//   timeline of each APB transfer from its latency rules, and a single negedge
//   process compares every DUT output against it each cycle.
module tb_apb_regbus_bridge;
  localparam int PAW = 12;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_regbus_bridge_if #(.PADDR_WIDTH(PAW), .DATA_WIDTH(DW)) apb_if ();

  logic [AW-1:0] reg_addr;
  logic          reg_cs, reg_we, reg_re;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic          reg_data_valid;

  apb_regbus_bridge #(
    .PADDR_WIDTH(PAW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb_if),
    .reg_addr(reg_addr), .reg_cs(reg_cs), .reg_we(reg_we), .reg_re(reg_re),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_data_valid(reg_data_valid)
  );

  // Register-file slave: write on cs&we, data_valid one cycle after cs&re.
  logic [DW-1:0] slv_mem [256];
  logic          slv_valid_q;
  logic          slv_mute = 1'b0;
  assign reg_rdata      = (reg_cs && reg_re) ? slv_mem[reg_addr] : '0;
  assign reg_data_valid = slv_valid_q && !slv_mute;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slv_valid_q <= 1'b0;
    else begin
      slv_valid_q <= reg_cs && reg_re && !slv_valid_q;
      if (reg_cs && reg_we) slv_mem[reg_addr] <= reg_wdata;
    end
  end

  // Expected outputs and architectural register contents.
  logic          e_pready = 0, e_pslverr = 0, e_cs = 0, e_we = 0, e_re = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_prdata = '0;
  logic [DW-1:0] m_mem [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("pready",    64'(apb_if.pready),  64'(e_pready));
    chk("pslverr",   64'(apb_if.pslverr), 64'(e_pslverr));
    chk("prdata",    64'(apb_if.prdata),  64'(e_prdata));
    chk("reg_cs",    64'(reg_cs),         64'(e_cs));
    chk("reg_we",    64'(reg_we),         64'(e_we));
    chk("reg_re",    64'(reg_re),         64'(e_re));
    chk("reg_addr",  64'(reg_addr),       64'(e_addr));
    chk("reg_wdata", 64'(reg_wdata),      64'(e_wdata));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_pready = 0; e_pslverr = 0; e_cs = 0; e_we = 0; e_re = 0;
  endtask

  task automatic idle(input int n);
    apb_if.psel = 0; apb_if.penable = 0;
    repeat (n) tick();
  endtask

  // Caller sits just after a posedge; this cycle is T0 of the transfer.
  task automatic xfer(input bit wr, input logic [PAW-1:0] a, input logic [DW-1:0] d);
    apb_if.psel = 1; apb_if.penable = 0; apb_if.pwrite = wr;
    apb_if.paddr = a; apb_if.pwdata = d;
    tick();                                  // T1
    apb_if.penable = 1;
    e_addr = a[AW-1:0]; e_wdata = d;
    if (a[PAW-1:AW] != 0) begin
      e_pready = 1; e_pslverr = 1;
      tick();
    end else if (wr) begin
      e_cs = 1; e_we = 1;
      tick();                                // T2
      e_cs = 0; e_we = 0; e_pready = 1;
      m_mem[a[AW-1:0]] = d;
      tick();
    end else begin
      e_cs = 1; e_re = 1;
      tick();                                // T2
      tick();                                // T3
      e_cs = 0; e_re = 0; e_pready = 1;
      e_prdata = m_mem[a[AW-1:0]];
      tick();
    end
    set_idle_exp();
  endtask

  // Read with the slave never answering.
  task automatic rd_stuck(input logic [PAW-1:0] a);
    slv_mute = 1;
    apb_if.psel = 1; apb_if.penable = 0; apb_if.pwrite = 0;
    apb_if.paddr = a; apb_if.pwdata = 32'h0BAD_0BAD;
    tick();
    apb_if.penable = 1;
    e_addr = a[AW-1:0]; e_wdata = 32'h0BAD_0BAD;
    e_cs = 1; e_re = 1;
    repeat (TO) tick();
`ifdef APB_REGBUS_TIMEOUT_EN
    e_cs = 0; e_re = 0; e_pready = 1; e_pslverr = 1; e_prdata = '0;
    tick();
`else
    repeat (4) tick();
    apb_if.psel = 0; apb_if.penable = 0;
    tick();
`endif
    set_idle_exp();
    slv_mute = 0;
  endtask

  // Read aborted by dropping psel during the first RD cycle.
  task automatic rd_abort(input logic [PAW-1:0] a);
    apb_if.psel = 1; apb_if.penable = 0; apb_if.pwrite = 0;
    apb_if.paddr = a; apb_if.pwdata = 32'h1111_2222;
    tick();
    apb_if.psel = 0; apb_if.penable = 0;
    e_addr = a[AW-1:0]; e_wdata = 32'h1111_2222;
    e_cs = 1; e_re = 1;
    tick();
    set_idle_exp();
  endtask

  initial begin
    apb_if.psel = 0; apb_if.penable = 0; apb_if.pwrite = 0;
    apb_if.paddr = '0; apb_if.pwdata = '0;
    #2;
    chk("rst_pready", 64'(apb_if.pready), 64'd0);
    chk("rst_prdata", 64'(apb_if.prdata), 64'd0);
    chk("rst_cs",     64'(reg_cs),        64'd0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    xfer(1, 12'h004, 32'hDEADBEEF);
    chk("lit_prdata_after_wr", 64'(apb_if.prdata), 64'd0);
    idle(2);

    xfer(0, 12'h004, 32'h0);
    chk("lit_rd_prdata", 64'(apb_if.prdata), 64'hDEADBEEF);
    idle(1);

    xfer(1, 12'h104, 32'hCAFEF00D);
    chk("lit_prdata_after_err", 64'(apb_if.prdata), 64'hDEADBEEF);
    idle(1);

    // penable without setup in IDLE is ignored.
    apb_if.psel = 1; apb_if.penable = 1; apb_if.pwrite = 1;
    apb_if.paddr = 12'h020; apb_if.pwdata = 32'h7777_7777;
    tick();
    idle(2);
    chk("lit_no_spurious_cs", 64'(reg_cs), 64'd0);

    xfer(1, 12'h000, 32'hA5A5_5A5A);
    xfer(0, 12'h000, 32'h0);
    chk("lit_b2b_prdata", 64'(apb_if.prdata), 64'hA5A5_5A5A);
    idle(2);

    rd_stuck(12'h00C);
    idle(3);

    rd_abort(12'h008);
    idle(2);
    chk("lit_prdata_after_abort", 64'(apb_if.prdata), 64'hA5A5_5A5A);

    // Reset asserted while the write strobe is up.
    apb_if.psel = 1; apb_if.penable = 0; apb_if.pwrite = 1;
    apb_if.paddr = 12'h010; apb_if.pwdata = 32'h1234_5678;
    tick();
    apb_if.penable = 1;
    e_addr = 8'h10; e_wdata = 32'h1234_5678; e_cs = 1; e_we = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_mid_cs",     64'(reg_cs),        64'd0);
    chk("rst_mid_we",     64'(reg_we),        64'd0);
    chk("rst_mid_addr",   64'(reg_addr),      64'd0);
    chk("rst_mid_wdata",  64'(reg_wdata),     64'd0);
    chk("rst_mid_prdata", 64'(apb_if.prdata), 64'd0);
    set_idle_exp();
    e_addr = '0; e_wdata = '0; e_prdata = '0;
    apb_if.psel = 0; apb_if.penable = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();

    xfer(1, 12'h0FF, 32'h0F0F_1234);
    xfer(0, 12'h0FF, 32'h0);
    chk("lit_recover_prdata", 64'(apb_if.prdata), 64'h0F0F_1234);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_regbus_bridge.md
Name: apb_regbus_bridge

Overview:
APB3 completer that converts APB transfers into the strobe-style register bus consumed by the generated register-file blocks: addr, chip_select, write_en, read_en, write_data, read_data and data_valid.
- Sits directly upstream of one register-file instance.
- Sequences one register-bus access per APB transfer and inserts wait states with pready.
- Returns read data, and reports out-of-range addresses and read timeouts through pslverr.

Parameters:
PADDR_WIDTH, 12, APB address width
ADDR_WIDTH, 8, register-bus address width (must be ≤ PADDR_WIDTH)
DATA_WIDTH, 32, data width of both buses
TIMEOUT_CYCLES, 16, maximum RD-state cycles waiting for reg_data_valid (used only with the optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB direction, 1 = write
paddr  input  PADDR_WIDTH  APB address
pwdata  input  DATA_WIDTH  APB write data
prdata  output  DATA_WIDTH  APB read data (registered)
pready  output  1  APB ready
pslverr  output  1  APB error (valid while pready=1)
reg_addr  output  ADDR_WIDTH  register-bus address
reg_cs  output  1  register-bus chip_select
reg_we  output  1  register-bus write_en
reg_re  output  1  register-bus read_en
reg_wdata  output  DATA_WIDTH  register-bus write data
reg_rdata  input  DATA_WIDTH  register-bus read_data (combinational from slave, valid while reg_cs&reg_re)
reg_data_valid  input  1  register-bus data_valid (slave asserts 1 cycle after reg_cs&reg_re)

Behaviour:
- Reset values: all outputs 0. State is IDLE. Latched address, data and error flag are 0.
- State machine: IDLE, WR, RD, RESP. All outputs are decoded from flops only; there is no combinational path from APB inputs to outputs.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch paddr[ADDR_WIDTH-1:0] into reg_addr and pwdata into reg_wdata.
  - If paddr[PADDR_WIDTH-1:ADDR_WIDTH] != 0, set err and go to RESP. No register-bus strobe is issued.
  - Otherwise go to WR if pwrite=1, or to RD if pwrite=0.
- WR: reg_cs=1 and reg_we=1 for exactly one cycle, then RESP.
- RD:
  - reg_cs=1 and reg_re=1 are held every cycle in this state.
  - When reg_data_valid=1, capture reg_rdata into prdata in that same cycle (strobes are still high) and go to RESP.
  - With the register-file slave this takes exactly 2 RD cycles.
- RESP:
  - pready=1, and pslverr=err. All strobes are 0.
  - When psel=1 and penable=1, go to IDLE and clear err. Otherwise hold RESP.
  - prdata holds its value until the next read capture. A write or error transfer does not change prdata.
- Latency, counted from the setup cycle T0:
  - Write: pready at T2.
  - Read: pready at T3.
  - Error: pready at T1.
  - pready is 0 in every state except RESP.
- Abort: psel=0 while in WR, RD or RESP returns the FSM to IDLE on the next edge, with strobes dropped and err cleared. A write already strobed is not undone.
- Protocol: penable=1 seen in IDLE without a preceding setup cycle is ignored.
- Back-to-back: a new setup is accepted in the IDLE cycle directly following RESP completion.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous).

Optional Feature:
APB_REGBUS_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RD and increments each RD cycle.
  - If reg_data_valid is still 0 when the count reaches TIMEOUT_CYCLES-1: set err, load prdata=0, go to RESP.
- Not defined: there is no counter, RD waits indefinitely, and pslverr is asserted only for address-range errors.

Test Plan:
- Write paddr=0x004, pwdata=0xDEADBEEF -> one-cycle reg_cs=reg_we=1 with reg_addr=0x04 and reg_wdata=0xDEADBEEF; pready=1 at T2; pslverr=0.
- Read paddr=0x004, slave returns 0xDEADBEEF with data_valid 1 cycle later -> reg_re high for 2 cycles; prdata=0xDEADBEEF; pready at T3; pslverr=0.
- Write to paddr=0x104 -> no reg_cs pulse; pready=1 and pslverr=1 at T1; prdata unchanged.
- With APB_REGBUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, reg_data_valid tied 0 -> reg_re high for 16 cycles, then pready=1, pslverr=1, prdata=0. Without the macro -> pready stays 0.
- Back-to-back write 0x00 then read 0x00 with no idle cycle -> read returns the written value; second setup accepted in the cycle after the first completes.
- Drop psel during RD, then assert rst_n=0 during a later WR -> FSM returns to IDLE with strobes 0; all outputs 0 immediately on reset.
